// File: rtl/mips_pkg.sv
// Shared definitions for the mips core: loader FSM encoding and the NOP word.
package mips_pkg;

    typedef enum logic {
        LDR_IDLE = 1'b0,
        LDR_LOAD = 1'b1
    } ldr_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x 32, one synchronous write port, one asynchronous read port.
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Write port: contents are never cleared, so they survive reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory: assembles a big-endian byte stream into words,
// writes them to the instruction RAM and serves the core's fetch port.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_start,
    input  logic [ADDR_W:0] load_len,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] words_loaded,
    output logic [31:0]     checksum,
    input  logic [31:0]     sel,
    output logic [31:0]     out
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [31:0]       csum_q, csum_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [ADDR_W:0]   words_inc;
    logic              sel_out_of_range;
    logic              unused_sel_lo;

    assign words_inc = words_q + 1'b1;

    // State and counter registers; reset abandons any load but leaves the RAM alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LDR_IDLE;
            addr_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            len_q   <= '0;
            words_q <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            words_q <= words_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state: length check on start, byte assembly and word write during LOAD.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        len_d     = len_q;
        words_d   = words_q;
        csum_d    = csum_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = {shift_q, byte_data};
        case (state_q)
            LDR_IDLE: begin
                if (load_start) begin
                    if (load_len == '0) begin
                        // An empty load completes immediately with nothing written.
                        done_d  = 1'b1;
                        words_d = '0;
                        csum_d  = '0;
                    end else if (load_len > DEPTH_L) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LDR_LOAD;
                        addr_d  = '0;
                        bcnt_d  = '0;
                        words_d = '0;
                        csum_d  = '0;
                        len_d   = load_len;
                    end
                end
            end
            LDR_LOAD: begin
                if (byte_valid) begin
                    if (bcnt_q == 2'd3) begin
                        // Fourth byte completes the word; write it this same edge.
                        ram_we  = 1'b1;
                        addr_d  = addr_q + 1'b1;
                        words_d = words_inc;
                        csum_d  = csum_q ^ ram_wdata;
                        bcnt_d  = '0;
                        if (words_inc == len_q) begin
                            state_d = LDR_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[15:0], byte_data};
                        bcnt_d  = bcnt_q + 2'd1;
                    end
                end
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (ram_wdata),
        .raddr (sel[ADDR_W+1:2]),
        .rdata (ram_rdata)
    );

    // Byte-lane bits of the fetch address do not select anything.
    assign unused_sel_lo    = ^sel[1:0];
    assign sel_out_of_range = |sel[31:ADDR_W+2];

    assign byte_ready   = (state_q == LDR_LOAD);
    assign cpu_hold     = (state_q == LDR_LOAD);
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;
    assign checksum     = csum_q;
    assign out          = (cpu_hold || sel_out_of_range) ? NOP_WORD : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a word-level memory model.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            load_start = 1'b0;
    logic [ADDR_W:0] load_len = '0;
    logic            byte_valid = 1'b0;
    logic [7:0]      byte_data = '0;
    logic            byte_ready;
    logic            cpu_hold;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] words_loaded;
    logic [31:0]     checksum;
    logic [31:0]     sel = '0;
    logic [31:0]     out;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] wbuf  [DEPTH];
    logic [31:0] last_csum;
    int          last_words;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded), .checksum(checksum), .sel(sel), .out(out)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_out(input logic [31:0] s);
        if (s >= 32'(DEPTH * 4)) return 32'h0;
        return mem_m[s / 4];
    endfunction

    task automatic chk_fetch(input string tag, input logic [31:0] s);
        sel = s;
        #1;
        chk(tag, out, exp_out(s));
    endtask

    // Runs a whole load of n words from wbuf. stall: 0 none, 1 alternate (low first), 2 random.
    // poke >= 0 pulses load_start at that cycle of the load.
    task automatic do_load(input int n, input int stall, input int poke, input string tag);
        int bi = 0;
        int cyc = 0;
        int hold_cnt = 0;
        int budget = 16 * n + 16;
        logic [31:0] x = 32'h0;
        logic v;
        for (int i = 0; i < n; i++) x ^= wbuf[i];
        sel = 32'h0;
        load_start = 1'b1;
        load_len = n[ADDR_W:0];
        tick;
        load_start = 1'b0;
        chk({tag, "_ready_rise"}, {31'b0, byte_ready}, 32'h1);
        while (bi < 4 * n && cyc < budget) begin
            case (stall)
                0: v = 1'b1;
                1: v = cyc[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (cpu_hold) hold_cnt++;
            if (cyc == 3) begin
                sel = 32'h4;
                #1;
                chk({tag, "_out_nop_in_load"}, out, 32'h0);
            end
            load_start = (cyc == poke);
            load_len = 9'd1;
            byte_valid = v;
            byte_data = 8'(wbuf[bi / 4] >> (8 * (3 - bi % 4)));
            tick;
            if (v) bi++;
            cyc++;
        end
        byte_valid = 1'b0;
        load_start = 1'b0;
        chk({tag, "_bytes_sent"}, bi, 4 * n);
        chk({tag, "_hold_cycles"}, hold_cnt, cyc);
        if (stall == 0) chk({tag, "_hold_4n"}, hold_cnt, 4 * n);
        if (stall == 1) chk({tag, "_hold_8n"}, hold_cnt, 8 * n);
        chk({tag, "_done"}, {31'b0, load_done}, 32'h1);
        chk({tag, "_hold_fall"}, {31'b0, cpu_hold}, 32'h0);
        chk({tag, "_words"}, 32'(words_loaded), n);
        chk({tag, "_csum"}, checksum, x);
        for (int i = 0; i < n; i++) mem_m[i] = wbuf[i];
        last_csum = x;
        last_words = n;
        tick;
        chk({tag, "_done_drop"}, {31'b0, load_done}, 32'h0);
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_ready", {31'b0, byte_ready}, 32'h0);
        chk("rst_hold", {31'b0, cpu_hold}, 32'h0);
        chk("rst_done", {31'b0, load_done}, 32'h0);
        chk("rst_err", {31'b0, load_err}, 32'h0);
        chk("rst_words", 32'(words_loaded), 32'h0);
        chk("rst_csum", checksum, 32'h0);
        sel = 32'h0000_0400;
        #1;
        chk("rst_out_range", out, 32'h0);

        // Simultaneous reset and load_start: reset wins
        load_start = 1'b1;
        load_len = 9'd4;
        tick;
        load_start = 1'b0;
        reset = 1'b0;
        chk("rst_vs_start", {31'b0, cpu_hold}, 32'h0);
        tick;
        chk("rst_vs_start2", {31'b0, cpu_hold}, 32'h0);

        // Full-depth load fills the whole model with random words
        for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
        do_load(DEPTH, 0, -1, "full");
        for (int k = 0; k < 8; k++) chk_fetch("full_fetch", {22'b0, 8'($urandom), 2'($urandom)});
        chk_fetch("full_fetch_last", 32'h0000_03FC);

        // Basic load
        wbuf[0] = 32'h2008_0005;
        wbuf[1] = 32'hAC01_0004;
        do_load(2, 0, -1, "basic");
        chk("basic_csum_const", checksum, 32'h8C09_0001);
        chk_fetch("basic_sel4", 32'h4);
        chk_fetch("basic_sel0", 32'h0);
        chk_fetch("fetch_sel7", 32'h7);
        chk_fetch("fetch_sel400", 32'h0000_0400);
        chk_fetch("fetch_high", 32'h8000_0008);
        chk_fetch("basic_sel8", 32'h8);

        // Stalled producer
        do_load(2, 1, -1, "stall");
        chk_fetch("stall_sel4", 32'h4);

        // Randomized loads with random stalls, one with load_start poked mid-load
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) wbuf[i] = $urandom;
            do_load(n, 2, (r == 1) ? 5 : -1, "rand");
            for (int k = 0; k < 3; k++) chk_fetch("rand_fetch", {24'b0, 6'($urandom_range(0, 15)), 2'($urandom)});
        end

        // Length zero: done next cycle, no hold
        load_start = 1'b1;
        load_len = 9'd0;
        tick;
        load_start = 1'b0;
        chk("len0_done", {31'b0, load_done}, 32'h1);
        chk("len0_hold", {31'b0, cpu_hold}, 32'h0);
        chk("len0_err", {31'b0, load_err}, 32'h0);
        chk("len0_words", 32'(words_loaded), 32'h0);
        tick;
        chk("len0_done_drop", {31'b0, load_done}, 32'h0);

        // Do a small load so words/checksum are nonzero before the rejection test
        wbuf[0] = $urandom;
        do_load(1, 0, -1, "pre_err");

        // Length DEPTH+1: error pulse, state untouched
        load_start = 1'b1;
        load_len = 9'(DEPTH + 1);
        tick;
        load_start = 1'b0;
        chk("lenbig_err", {31'b0, load_err}, 32'h1);
        chk("lenbig_done", {31'b0, load_done}, 32'h0);
        chk("lenbig_hold", {31'b0, cpu_hold}, 32'h0);
        chk("lenbig_words", 32'(words_loaded), last_words);
        chk("lenbig_csum", checksum, last_csum);
        tick;
        chk("lenbig_err_drop", {31'b0, load_err}, 32'h0);
        chk_fetch("lenbig_ram0", 32'h0);
        chk_fetch("lenbig_ram1", 32'h4);

        // byte_valid in IDLE is not accepted
        for (int c = 0; c < 6; c++) begin
            byte_valid = 1'b1;
            byte_data = 8'($urandom);
            #1;
            if (c == 0) chk("idle_ready", {31'b0, byte_ready}, 32'h0);
            tick;
        end
        byte_valid = 1'b0;
        chk("idle_words", 32'(words_loaded), last_words);
        chk_fetch("idle_ram0", 32'h0);
        chk_fetch("idle_ram1", 32'h4);

        // Reset mid-load after 6 bytes
        for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
        load_start = 1'b1;
        load_len = 9'd3;
        tick;
        load_start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            byte_valid = 1'b1;
            byte_data = 8'(wbuf[b / 4] >> (8 * (3 - b % 4)));
            tick;
        end
        byte_valid = 1'b0;
        chk("midrst_words_pre", 32'(words_loaded), 32'h1);
        mem_m[0] = wbuf[0];
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst_ready", {31'b0, byte_ready}, 32'h0);
        chk("midrst_hold", {31'b0, cpu_hold}, 32'h0);
        chk("midrst_words", 32'(words_loaded), 32'h0);
        chk("midrst_csum", checksum, 32'h0);
        chk_fetch("midrst_ram0", 32'h0);
        chk_fetch("midrst_ram1", 32'h4);

        // A fresh load after the abandoned one starts on a clean byte group
        wbuf[0] = $urandom;
        do_load(1, 2, -1, "post_rst");
        chk_fetch("post_rst_ram0", 32'h0);
        chk_fetch("post_rst_ram1", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writable instruction memory for the mips core. It accepts a byte stream over a valid/ready handshake and assembles it into big-endian 32-bit words. It writes those words into its own instruction RAM and serves the core's fetch port with the same sel/out semantics as the current read-only instruction memory. While a load is in progress it asserts `cpu_hold`; the top level ORs this into the core's reset.

## Interface
Parameters:
- `ADDR_W`, 8: word-index width.
- `DEPTH`, 256: number of 32-bit words; must equal 2**ADDR_W.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: reset is synchronous and active-high.
- `load_start`  in  1: one-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  ADDR_W+1: number of words to load; sampled with `load_start`.
- `byte_valid`  in  1: producer has a byte.
- `byte_data`  in  8: stream byte.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `cpu_hold`  out  1: high while in LOAD.
- `load_done`  out  1: one-cycle pulse after the last word is written.
- `load_err`  out  1: one-cycle pulse on a rejected `load_len`.
- `words_loaded`  out  ADDR_W+1: words written in the current or last load.
- `checksum`  out  32: XOR of all words written in the current or last load.
- `sel`  in  32: fetch byte address from the PC.
- `out`  out  32: instruction word.

## Operation
- FSM states: IDLE and LOAD.
- IDLE → LOAD: `load_start`=1 and 1 ≤ `load_len` ≤ DEPTH.
  - At that edge, clear the word address, byte counter, `words_loaded` and `checksum`.
  - Latch `load_len`.
- IDLE, `load_start`=1, `load_len`=0: stay in IDLE; pulse `load_done` next cycle; `words_loaded`=0.
- IDLE, `load_start`=1, `load_len` > DEPTH: stay in IDLE; pulse `load_err` next cycle. RAM, `words_loaded` and `checksum` are untouched.
- LOAD: `byte_ready`=1. A byte is accepted on each edge where `byte_valid`&&`byte_ready`.
- Byte order is big-endian:
  - byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8].
  - Bytes 0–2 are held in a 24-bit shift register and byte counter 0..3 increments.
  - On byte 3, `{shift, byte_data}` is written to RAM[addr] at that same edge. Then addr+1, `words_loaded`+1, `checksum` ^= word, and the byte counter wraps to 0.
- LOAD → IDLE: on the edge that writes word number `load_len`. `load_done` pulses high for the following cycle.
- `load_start` while in LOAD: ignored.
- `byte_valid` while in IDLE: not accepted (`byte_ready`=0); no state change.
- Fetch port:
  - word index = `sel[ADDR_W+1:2]`; `sel[1:0]` ignored.
  - `out` is a combinational read of RAM.
  - `sel[31:ADDR_W+2]` ≠ 0 → `out`=0 (nop).
  - While `cpu_hold`=1 → `out`=0.
- Reset:
  - FSM → IDLE; counters, `words_loaded` and `checksum` → 0; all outputs deasserted.
  - RAM contents are not cleared.
  - Reset mid-load abandons the load. Words already written remain, and a partial byte group is discarded.

## Timing
- Reset values: `byte_ready`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, `words_loaded`=0, `checksum`=0. `out` follows RAM (0 for out-of-range `sel`).
- `cpu_hold` and `byte_ready` rise in the cycle after the accepting `load_start` edge and fall in the cycle after the final-byte edge.
- Sustained `byte_valid`=1 gives throughput of 1 byte/cycle; a load of N words takes 4N cycles in LOAD.
- A written word is visible on `out` (via `sel`) from the first cycle with `cpu_hold`=0, i.e. the cycle `load_done` is high.
- `words_loaded` and `checksum` update at the same edge as the RAM write.
- Simultaneous `reset` and `load_start`: reset wins.

## Structure
- Shared package `mips_pkg`: FSM state encoding (`LDR_IDLE`, `LDR_LOAD`) and a NOP word constant (32'h0).
- One sub-module, `imem_ram`: DEPTH×32 array with one synchronous write port and one asynchronous read port. The FSM, byte assembler, counters and fetch-range check stay in `imem_loader`.

## Test plan
- Basic load:
  - Stimulus: `load_len`=2; bytes 20,08,00,05,AC,01,00,04 sent back-to-back.
  - Response: RAM[0]=32'h20080005, RAM[1]=32'hAC010004; `load_done` pulses 8 cycles after LOAD entry; `words_loaded`=2; `checksum`=32'h8C090001; `sel`=4 → `out`=32'hAC010004.
- Stalled producer:
  - Stimulus: same stream with `byte_valid` low on alternate cycles.
  - Response: identical RAM contents and checksum; `cpu_hold` lasts 16 cycles.
- Length rejection:
  - `load_len`=0 → `load_done` next cycle, no `cpu_hold`.
  - `load_len`=DEPTH+1 → `load_err` pulse; RAM and `checksum` unchanged.
- Fetch range:
  - `sel`=32'h00000400 (DEPTH=256) → `out`=0.
  - `sel`=32'h00000007 → returns RAM[1].
  - `out`=0 throughout LOAD.
- Reset mid-load:
  - Stimulus: `load_len`=3; assert `reset` after 6 bytes.
  - Response: RAM[0] holds word 0, RAM[1] is unchanged; FSM in IDLE; `words_loaded`=0; `byte_ready`=0.
- Ignored inputs:
  - `load_start` pulsed during LOAD → no restart; counters continue.
  - `byte_valid` in IDLE → no RAM write.
